cdb_rr_arbiter: RTL and testbench
=================================

CDB_RR_ARBITER -- requirements
Module: cdb_rr_arbiter

Interface
REQ-001 Parameter N, default 16: number of requesting functional units / reservation-station sources.
REQ-002 Parameter K, default 2: number of common data bus channels granted per cycle; 1 <= K <= N.
REQ-003 Parameter IDXW, default $clog2(N): width of one source index.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 request  input  N  bit i high = source i holds a completed result for the CDB.
REQ-007 stall  input  1  high = CDB unavailable this cycle; no grants.
REQ-008 grant  output  N  bit i high = source i drives a CDB channel this cycle; popcount <= K.
REQ-009 bus_valid  output  K  bit j high = channel j carries a granted source.
REQ-010 bus_source  output  K*IDXW  slice j = index of the source on channel j; 0 when bus_valid[j] is low.
REQ-011 cdb_active  output  1  high when any grant bit is high.
REQ-012 priority_ptr  output  IDXW  current round-robin start index (debug/verification visibility).

Function
REQ-013 grant, bus_valid, bus_source and cdb_active SHALL be combinational in request, stall, reset and the registered pointer (zero-latency grant).
REQ-014 The scan order SHALL be priority_ptr, priority_ptr+1, ..., wrapping mod N back to priority_ptr-1.
REQ-015 The first K requesting sources in scan order SHALL be granted; the j-th found SHALL be placed on channel j (channel 0 = highest priority).
REQ-016 Channels with no granted source SHALL have bus_valid low and bus_source 0; channels SHALL fill contiguously from channel 0.
REQ-017 When K >= popcount(request), every requesting source SHALL be granted.
REQ-018 On a clk edge with at least one grant, priority_ptr SHALL become (index of the last granted source in scan order + 1) mod N.
REQ-019 On a clk edge with no grant (request == 0 or stall high), priority_ptr SHALL hold.
REQ-020 Pointer wrap from N-1 SHALL go to 0; N not a power of two SHALL never yield a pointer >= N.
REQ-021 stall high SHALL force grant = 0, bus_valid = 0, bus_source = 0 and cdb_active = 0, regardless of request.
REQ-022 Fairness: a source holding request high continuously without stall SHALL be granted within ceil(N/K) cycles.
REQ-023 cdb_active SHALL equal OR of grant at all times.
REQ-024 Any single source SHALL appear in at most one channel per cycle.

Reset
REQ-025 reset high SHALL set priority_ptr to 0 immediately, without waiting for a clk edge.
REQ-026 While reset is high, grant, bus_valid, bus_source and cdb_active SHALL be 0, and priority_ptr SHALL remain 0 across clk edges.
REQ-027 Reset asserted mid-operation SHALL discard the pointer position; the first cycle after release SHALL scan from index 0.

Verification (N=16, K=2)
REQ-028 Reset asserted, request=16'hFFFF -> grant=0, cdb_active=0, priority_ptr=0.
REQ-029 After reset, request=16'h0007 held -> cycle 1: grant=16'h0003, bus_source={1,0}, ptr becomes 2; cycle 2: grant=16'h0005, channel0=2, channel1=0 (wrap), ptr becomes 1.
REQ-030 request=16'hFFFF held 9 cycles from ptr 0 -> grants 16'h0003, 16'h000C, ..., 16'hC000, then 16'h0003 again (ptr wraps 14 -> 0).
REQ-031 stall=1 with request=16'hFFFF at ptr 6 for 3 cycles -> grant=0, bus_valid=0, cdb_active=0, ptr stays 6; stall drop -> grant=16'h00C0.
REQ-032 ptr 0, request=16'h8000 -> grant=16'h8000, bus_valid=2'b01, channel0=15, channel1=0; ptr becomes 0 (wrap).
REQ-033 ptr 5, reset pulsed between clk edges -> priority_ptr reads 0 before the next edge; after release, request=16'h0021 -> grant=16'h0021, channel0=0, channel1=5.

Source files
------------

// File: rtl/cdb_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// CdbRrArbiterIf
// Bundles the request/grant signals between the reservation-station sources
// and the common data bus arbiter.
//
//   request      : N        one bit per source holding a finished result
//   stall        : 1        CDB unavailable this cycle
//   grant        : N        one bit per source driving a channel this cycle
//   bus_valid    : K        one bit per channel carrying a granted source
//   bus_source   : K*IDXW   packed source index per channel (0 when idle)
//   cdb_active   : 1        any grant this cycle
//   priority_ptr : IDXW     current round-robin start index
//
// Modports:
//   master : the side that raises requests and watches the grants
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface cdb_rr_arbiter_if #(
    parameter int N    = 16,
    parameter int K    = 2,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]      request;
    logic              stall;
    logic [N-1:0]      grant;
    logic [K-1:0]      bus_valid;
    logic [K*IDXW-1:0] bus_source;
    logic              cdb_active;
    logic [IDXW-1:0]   priority_ptr;

    modport master (
        output request,
        output stall,
        input  grant,
        input  bus_valid,
        input  bus_source,
        input  cdb_active,
        input  priority_ptr
    );

    modport slave (
        input  request,
        input  stall,
        output grant,
        output bus_valid,
        output bus_source,
        output cdb_active,
        output priority_ptr
    );
endinterface

// File: rtl/cdb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_rr_arbiter
// Round-robin arbiter granting up to K common data bus channels per cycle
// among N requesting sources. Grants are combinational (zero latency); only
// the round-robin start pointer is registered.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   arb    : CdbRrArbiterIf slave modport (request/stall in, grants out)
// ---------------------------------------------------------------------------
module cdb_rr_arbiter #(
    parameter int N    = 16,
    parameter int K    = 2,
    parameter int IDXW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    cdb_rr_arbiter_if.slave   arb
);

    logic [IDXW-1:0]   ptr_q;
    logic [IDXW-1:0]   ptr_d;
    logic [N-1:0]      grantComb;
    logic [K-1:0]      busValidComb;
    logic [K*IDXW-1:0] busSourceComb;
    int                found;
    int                scanIdx;

    // Walk all N sources starting at the pointer, wrapping modulo N, and hand
    // channels out in the order requesters are found. The scan index is
    // formed in plain int arithmetic and folded by a single subtraction so a
    // non-power-of-two N can never produce an out-of-range index. The next
    // pointer tracks one past the most recent grant; with no grant it holds.
    always_comb begin
        grantComb     = '0;
        busValidComb  = '0;
        busSourceComb = '0;
        ptr_d         = ptr_q;
        found         = 0;
        scanIdx       = 0;
        if (!reset && !arb.stall) begin
            for (int s = 0; s < N; s++) begin
                scanIdx = int'(ptr_q) + s;
                if (scanIdx >= N) begin
                    scanIdx = scanIdx - N;
                end
                if (arb.request[scanIdx] && (found < K)) begin
                    grantComb[scanIdx]                     = 1'b1;
                    busValidComb[found]                    = 1'b1;
                    busSourceComb[found*IDXW +: IDXW]      = IDXW'(scanIdx);
                    ptr_d = (scanIdx == N - 1) ? '0 : IDXW'(scanIdx + 1);
                    found = found + 1;
                end
            end
        end
    end

    // Pointer register; reset clears it immediately and keeps it at zero for
    // as long as reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // Drive the interface outputs.
    assign arb.grant        = grantComb;
    assign arb.bus_valid    = busValidComb;
    assign arb.bus_source   = busSourceComb;
    assign arb.cdb_active   = |grantComb;
    assign arb.priority_ptr = ptr_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_rr_arbiter
// Directed testbench for cdb_rr_arbiter with N=16, K=2. Expected values are
// hand-computed constants for each vector.
// ---------------------------------------------------------------------------
module tb_cdb_rr_arbiter;

    localparam int N    = 16;
    localparam int K    = 2;
    localparam int IDXW = 4;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    cdb_rr_arbiter_if #(.N(N), .K(K), .IDXW(IDXW)) arbIf ();

    cdb_rr_arbiter #(.N(N), .K(K), .IDXW(IDXW)) dut (
        .clk   (clk),
        .reset (reset),
        .arb   (arbIf.slave)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive request/stall, then let the combinational outputs settle.
    task automatic applyStimulus(input logic [N-1:0] req, input logic stl);
        arbIf.request = req;
        arbIf.stall   = stl;
        #1;
    endtask

    // Advance past the next rising edge, landing 1 unit after it.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Short asynchronous reset pulse placed between clock edges.
    task automatic pulseReset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    logic [N-1:0] expGrant;

    // Directed sequence covering reset, rotation, wrap, stall and the
    // single-requester and mid-cycle reset corner cases.
    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset       = 1'b1;
        arbIf.request = '0;
        arbIf.stall   = 1'b0;

        // Reset held with every source requesting, across two edges.
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("rst_grant", 32'(arbIf.grant), 32'h0);
        checkOutput("rst_active", 32'(arbIf.cdb_active), 32'h0);
        checkOutput("rst_valid", 32'(arbIf.bus_valid), 32'h0);
        checkOutput("rst_ptr", 32'(arbIf.priority_ptr), 32'h0);
        stepClock();
        stepClock();
        checkOutput("rst_ptr_hold", 32'(arbIf.priority_ptr), 32'h0);
        checkOutput("rst_grant_hold", 32'(arbIf.grant), 32'h0);

        // Three low sources: first cycle takes 0 and 1, second wraps to 2 then 0.
        reset = 1'b0;
        applyStimulus(16'h0007, 1'b0);
        checkOutput("r7_c1_grant", 32'(arbIf.grant), 32'h0003);
        checkOutput("r7_c1_src", 32'(arbIf.bus_source), 32'h10);
        checkOutput("r7_c1_valid", 32'(arbIf.bus_valid), 32'h3);
        stepClock();
        checkOutput("r7_ptr2", 32'(arbIf.priority_ptr), 32'h2);
        checkOutput("r7_c2_grant", 32'(arbIf.grant), 32'h0005);
        checkOutput("r7_c2_src", 32'(arbIf.bus_source), 32'h02);
        stepClock();
        checkOutput("r7_ptr1", 32'(arbIf.priority_ptr), 32'h1);

        // All sources requesting from pointer 0: pairs rotate and wrap.
        pulseReset();
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("full_ptr0", 32'(arbIf.priority_ptr), 32'h0);
        for (int i = 0; i < 9; i++) begin
            expGrant = 16'h0003 << (2 * (i % 8));
            checkOutput($sformatf("full_grant%0d", i), 32'(arbIf.grant), 32'(expGrant));
            stepClock();
        end
        checkOutput("full_ptr_end", 32'(arbIf.priority_ptr), 32'h2);

        // Move the pointer to 6, then stall for three cycles.
        stepClock();
        stepClock();
        checkOutput("pre_stall_ptr", 32'(arbIf.priority_ptr), 32'h6);
        applyStimulus(16'hFFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall_grant%0d", i), 32'(arbIf.grant), 32'h0);
            checkOutput($sformatf("stall_valid%0d", i), 32'(arbIf.bus_valid), 32'h0);
            checkOutput($sformatf("stall_src%0d", i), 32'(arbIf.bus_source), 32'h0);
            checkOutput($sformatf("stall_active%0d", i), 32'(arbIf.cdb_active), 32'h0);
            stepClock();
            checkOutput($sformatf("stall_ptr%0d", i), 32'(arbIf.priority_ptr), 32'h6);
        end
        applyStimulus(16'hFFFF, 1'b0);
        checkOutput("unstall_grant", 32'(arbIf.grant), 32'h00C0);
        checkOutput("unstall_src", 32'(arbIf.bus_source), 32'h76);
        checkOutput("unstall_active", 32'(arbIf.cdb_active), 32'h1);

        // Lone top source from pointer 0: one channel used, pointer wraps to 0.
        pulseReset();
        applyStimulus(16'h8000, 1'b0);
        checkOutput("top_grant", 32'(arbIf.grant), 32'h8000);
        checkOutput("top_valid", 32'(arbIf.bus_valid), 32'h1);
        checkOutput("top_src", 32'(arbIf.bus_source), 32'h0F);
        stepClock();
        checkOutput("top_ptr", 32'(arbIf.priority_ptr), 32'h0);

        // Pointer to 5 via source 4, then reset between edges clears it at once.
        applyStimulus(16'h0010, 1'b0);
        checkOutput("s4_grant", 32'(arbIf.grant), 32'h0010);
        stepClock();
        checkOutput("s4_ptr", 32'(arbIf.priority_ptr), 32'h5);
        reset = 1'b1;
        #1;
        checkOutput("async_ptr", 32'(arbIf.priority_ptr), 32'h0);
        checkOutput("async_grant", 32'(arbIf.grant), 32'h0);
        reset = 1'b0;
        applyStimulus(16'h0021, 1'b0);
        checkOutput("post_rst_grant", 32'(arbIf.grant), 32'h0021);
        checkOutput("post_rst_src", 32'(arbIf.bus_source), 32'h50);
        stepClock();
        checkOutput("post_rst_ptr", 32'(arbIf.priority_ptr), 32'h6);

        // No requests: no grant and the pointer holds.
        applyStimulus(16'h0000, 1'b0);
        checkOutput("idle_active", 32'(arbIf.cdb_active), 32'h0);
        stepClock();
        checkOutput("idle_ptr", 32'(arbIf.priority_ptr), 32'h6);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
